// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period, idle polarity and burst length,
// with single-cycle leading/trailing edge strobes in the clk domain.
module spi_sclk_gen #(
  parameter int DIV_W = 16,
  parameter int BIT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [BIT_W-1:0] num_bits,
  input  logic             cpol,
  output logic             sclk,
  output logic             lead_pulse,
  output logic             trail_pulse,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | sclk follows cpol, waiting for a start with num_bits != 0
  // RUN   | toggling sclk every div_q+1 cycles until 2*bits_q edges
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx, div_q, div_q_nx;
  logic [BIT_W-1:0] bits_q, bits_q_nx;
  logic [BIT_W:0]   edges, edges_nx, last_edge;
  logic             cpol_q, cpol_q_nx;
  logic             sclk_nx, lead_nx, trail_nx, busy_nx, done_nx;

  assign last_edge = {bits_q, 1'b0} - (BIT_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      edges       <= '0;
      div_q       <= '0;
      bits_q      <= '0;
      cpol_q      <= 1'b0;
      sclk        <= 1'b0;
      lead_pulse  <= 1'b0;
      trail_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      edges       <= edges_nx;
      div_q       <= div_q_nx;
      bits_q      <= bits_q_nx;
      cpol_q      <= cpol_q_nx;
      sclk        <= sclk_nx;
      lead_pulse  <= lead_nx;
      trail_pulse <= trail_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    edges_nx  = edges;
    div_q_nx  = div_q;
    bits_q_nx = bits_q;
    cpol_q_nx = cpol_q;
    sclk_nx   = sclk;
    lead_nx   = 1'b0;
    trail_nx  = 1'b0;
    busy_nx   = busy;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        sclk_nx = cpol;
        if (start && (num_bits != '0)) begin
          div_q_nx  = div;
          bits_q_nx = num_bits;
          cpol_q_nx = cpol;
          cnt_nx    = '0;
          edges_nx  = '0;
          busy_nx   = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          // abort overrides even a coincident final edge: no strobes, no done
          state_nx = IDLE;
          sclk_nx  = cpol_q;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
          edges_nx = '0;
        end else if (cnt == div_q) begin
          cnt_nx   = '0;
          sclk_nx  = ~sclk;
          edges_nx = edges + (BIT_W+1)'(1);
          if (edges[0]) trail_nx = 1'b1;
          else          lead_nx  = 1'b1;
          if (edges == last_edge) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + DIV_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: hand-computed burst timing, strobe counts, guard,
// abort, reset and maximum-value cases (max values on a narrow second instance).
module tb_spi_sclk_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort, cpol;
  logic [15:0] div;
  logic [5:0]  num_bits;
  logic        sclk, lead_pulse, trail_pulse, busy, done;

  logic        start2, abort2, cpol2;
  logic [3:0]  div2;
  logic [1:0]  nb2;
  logic        sclk2, lead2, trail2, busy2, done2;

  logic        sel;
  logic        s_sclk, s_lead, s_trail, s_busy, s_done;

  int n_chk = 0, n_fail = 0;
  int m_busy, m_lead, m_trail, m_done, m_bad, m_first, m_tmo;

  always #5 clk = ~clk;

  spi_sclk_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .div(div),
    .num_bits(num_bits), .cpol(cpol), .sclk(sclk), .lead_pulse(lead_pulse),
    .trail_pulse(trail_pulse), .busy(busy), .done(done)
  );

  spi_sclk_gen #(.DIV_W(4), .BIT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .div(div2),
    .num_bits(nb2), .cpol(cpol2), .sclk(sclk2), .lead_pulse(lead2),
    .trail_pulse(trail2), .busy(busy2), .done(done2)
  );

  assign s_sclk  = sel ? sclk2  : sclk;
  assign s_lead  = sel ? lead2  : lead_pulse;
  assign s_trail = sel ? trail2 : trail_pulse;
  assign s_busy  = sel ? busy2  : busy;
  assign s_done  = sel ? done2  : done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on the sample right after the start-accepting edge (index 0); runs until busy
  // drops. Optionally pokes start/div/cpol mid-burst at poke_idx and restores them later.
  task automatic measure(input int limit, input logic cp, input int poke_idx);
    int idx;
    logic [15:0] div_save;
    div_save = div;
    m_busy = 0; m_lead = 0; m_trail = 0; m_done = 0; m_bad = 0; m_first = -1; m_tmo = 1;
    for (idx = 0; idx < limit; idx++) begin
      if (poke_idx >= 0) begin
        if (idx == poke_idx) begin
          start = 1'b1; div = div_save + 16'd5; cpol = ~cp;
        end else if (idx == poke_idx + 1) begin
          start = 1'b0;
        end else if (idx == poke_idx + 6) begin
          div = div_save; cpol = cp;
        end
      end
      if (s_busy) m_busy++;
      if (s_lead) begin
        m_lead++;
        if (m_first < 0) m_first = idx;
        if (s_sclk !== ~cp) m_bad++;
      end
      if (s_trail) begin
        m_trail++;
        if (s_sclk !== cp) m_bad++;
      end
      if (s_done) m_done++;
      if (!s_busy) begin
        m_tmo = 0;
        break;
      end
      step();
    end
  endtask

  initial begin
    int d;
    sel = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cpol = 1'b0; div = '0; num_bits = '0;
    start2 = 1'b0; abort2 = 1'b0; cpol2 = 1'b0; div2 = '0; nb2 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lead", lead_pulse, 0);
    chk("rst_trail", trail_pulse, 0);

    // div=0, num_bits=2, cpol=0: cycle-exact waveform
    div = 16'd0; num_bits = 6'd2; cpol = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    chk("t0_busy", busy, 1);
    chk("t0_sclk", sclk, 0);
    step();
    chk("t1_sclk", sclk, 1);
    chk("t1_lead", lead_pulse, 1);
    chk("t1_trail", trail_pulse, 0);
    step();
    chk("t2_sclk", sclk, 0);
    chk("t2_trail", trail_pulse, 1);
    chk("t2_lead", lead_pulse, 0);
    step();
    chk("t3_sclk", sclk, 1);
    chk("t3_lead", lead_pulse, 1);
    chk("t3_done", done, 0);
    step();
    chk("t4_sclk", sclk, 0);
    chk("t4_trail", trail_pulse, 1);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    step();
    chk("t5_done", done, 0);

    // div=3, num_bits=8, cpol=1
    cpol = 1'b1; div = 16'd3; num_bits = 6'd8;
    step();
    chk("c1_idle", sclk, 1);
    start = 1'b1; step(); start = 1'b0;
    measure(200, 1'b1, -1);
    chk("c1_tmo", m_tmo, 0);
    chk("c1_busy", m_busy, 64);
    chk("c1_lead", m_lead, 8);
    chk("c1_trail", m_trail, 8);
    chk("c1_done", m_done, 1);
    chk("c1_dir", m_bad, 0);
    chk("c1_first", m_first, 4);
    step();
    chk("c1_after", sclk, 1);

    // num_bits=0 start is ignored
    num_bits = 6'd0; div = 16'd0; start = 1'b1;
    step(); start = 1'b0; step();
    chk("z_busy", busy, 0);
    chk("z_done", done, 0);
    chk("z_sclk", sclk, 1);

    // mid-burst start/div/cpol changes have no effect
    cpol = 1'b0; div = 16'd1; num_bits = 6'd4; start = 1'b1;
    step(); start = 1'b0;
    measure(100, 1'b0, 3);
    chk("g_tmo", m_tmo, 0);
    chk("g_busy", m_busy, 16);
    chk("g_lead", m_lead, 4);
    chk("g_trail", m_trail, 4);
    chk("g_dir", m_bad, 0);
    chk("g_done", m_done, 1);

    // abort at cycle 10 of div=1, num_bits=8
    div = 16'd1; num_bits = 6'd8; cpol = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      d += int'(done);
      step();
    end
    chk("a_pre_sclk", sclk, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("a_sclk", sclk, 0);
    chk("a_busy", busy, 0);
    chk("a_done", done | (d != 0), 0);
    chk("a_lead", lead_pulse, 0);
    chk("a_trail", trail_pulse, 0);
    // restart with abort and start together in IDLE
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    measure(100, 1'b0, -1);
    chk("ar_tmo", m_tmo, 0);
    chk("ar_busy", m_busy, 32);
    chk("ar_lead", m_lead, 8);
    chk("ar_trail", m_trail, 8);
    chk("ar_done", m_done, 1);

    // abort coincident with the final edge
    div = 16'd0; num_bits = 6'd1; start = 1'b1;
    step(); start = 1'b0; step();
    chk("af_lead", lead_pulse, 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("af_done", done, 0);
    chk("af_trail", trail_pulse, 0);
    chk("af_busy", busy, 0);
    chk("af_sclk", sclk, 0);

    // reset mid-burst
    cpol = 1'b1; div = 16'd2; num_bits = 6'd4; start = 1'b1;
    step(); start = 1'b0;
    repeat (7) step();
    chk("r_pre_busy", busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("r_sclk", sclk, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_pulses", {lead_pulse, trail_pulse}, 0);
    cpol = 1'b0; div = 16'd0; num_bits = 6'd2; start = 1'b1;
    step(); start = 1'b0;
    measure(50, 1'b0, -1);
    chk("r2_busy", m_busy, 4);
    chk("r2_lead", m_lead, 2);
    chk("r2_trail", m_trail, 2);
    chk("r2_done", m_done, 1);
    chk("r2_first", m_first, 1);

    // back-to-back bursts
    div = 16'd2; num_bits = 6'd3; start = 1'b1;
    step(); start = 1'b0;
    measure(100, 1'b0, -1);
    chk("b1_busy", m_busy, 18);
    chk("b1_first", m_first, 3);
    start = 1'b1; step(); start = 1'b0;
    measure(100, 1'b0, -1);
    chk("b2_tmo", m_tmo, 0);
    chk("b2_busy", m_busy, 18);
    chk("b2_first", m_first, 3);
    chk("b2_lead", m_lead, 3);
    chk("b2_done", m_done, 1);

    // all-ones divide and maximum bit count on the narrow instance
    sel = 1'b1;
    div2 = 4'hF; nb2 = 2'd3; cpol2 = 1'b0; start2 = 1'b1;
    step(); start2 = 1'b0;
    measure(300, 1'b0, -1);
    chk("m_tmo", m_tmo, 0);
    chk("m_busy", m_busy, 96);
    chk("m_lead", m_lead, 3);
    chk("m_trail", m_trail, 3);
    chk("m_done", m_done, 1);
    chk("m_first", m_first, 16);
    nb2 = 2'd1; start2 = 1'b1;
    step(); start2 = 1'b0;
    measure(100, 1'b0, -1);
    chk("m1_busy", m_busy, 32);
    chk("m1_done", m_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
